// File: rtl/nios_system_de2_key_pkg.sv
// Shared types and defaults for the DE2 pushbutton debouncer.
// Default timing is 20 ms of stable input at a 50 MHz system clock.
package nios_system_de2_key_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_CNT_W           = 24;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        WAIT_DOWN = 2'd1,
        DOWN      = 2'd2,
        WAIT_UP   = 2'd3
    } key_state_e;

endpackage

// File: rtl/nios_system_de2_key_debounce_ch.sv
// One pushbutton channel: 2-flop synchronizer, qualify FSM with a stability
// counter, and registered level / press / release outputs.
module nios_system_de2_key_debounce_ch
    import nios_system_de2_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             pressed;

    // Buttons are active-low; everything past the synchronizer is "1 = pressed".
    assign pressed = ~sync_q;

    always_comb begin
        meta_d    = key_n;
        sync_d    = meta_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            UP: begin
                if (pressed) begin
                    state_d = WAIT_DOWN;
                    cnt_d   = '0;
                end
            end
            WAIT_DOWN: begin
                if (!pressed) begin
                    state_d = UP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DOWN;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DOWN: begin
                if (!pressed) begin
                    state_d = WAIT_UP;
                    cnt_d   = '0;
                end
            end
            WAIT_UP: begin
                if (pressed) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = UP;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = UP;
                cnt_d   = '0;
            end
        endcase
        // Level follows the next state so it rises on the same edge as the pulse.
        level_d = (state_d == DOWN) || (state_d == WAIT_UP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q    <= 1'b1;
            sync_q    <= 1'b1;
            state_q   <= UP;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/nios_system_de2_key_debounce.sv
// Debouncer for the DE2 pushbuttons: NUM_KEYS independent channels feeding
// the keys PIO, plus one-clock press/release event pulses.
module nios_system_de2_key_debounce
    import nios_system_de2_key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        nios_system_de2_key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .key_n       (key_n[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_nios_system_de2_key_debounce.sv
// Directed bench for the key debouncer with DEBOUNCE_CYCLES=8 (11-edge latency).
// Expected pulse events are queued by the driver and consumed by a monitor.
module tb_nios_system_de2_key_debounce;

    localparam int NK  = 4;
    localparam int DC  = 8;
    localparam int LAT = DC + 3;
    localparam int W   = 32 + 3 * NK;

    logic          clk;
    logic          reset;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Expected event: {cycle, press, release, level after the event}.
    logic [W-1:0] exp_q[$];

    nios_system_de2_key_debounce #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: sim time limit reached, exp_q size=%0d", exp_q.size());
        $fatal(1, "timeout");
    end

    // Driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_event(input int at, input logic [NK-1:0] p,
                                input logic [NK-1:0] r, input logic [NK-1:0] l);
        exp_q.push_back({at[31:0], p, r, l});
    endtask

    task automatic check_level(input string name, input logic [NK-1:0] exp_l);
        vectors++;
        if (key_level !== exp_l) begin
            errors++;
            $display("FAIL %s: key_level=%b expected=%b (cyc %0d)", name, key_level, exp_l, cyc);
        end
    endtask

    // Monitor / scoreboard: any non-zero pulse vector must match the queue head.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!reset && ((key_press | key_release) != '0)) begin
            vectors++;
            if ((key_press & key_release) != '0) begin
                errors++;
                $display("FAIL overlap: press=%b release=%b at cyc %0d", key_press, key_release, cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: press=%b release=%b level=%b at cyc %0d expected none",
                         key_press, key_release, key_level, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e[W-1 -: 32] != cyc[31:0] || e[3*NK-1 -: NK] !== key_press ||
                    e[2*NK-1 -: NK] !== key_release || e[NK-1:0] !== key_level) begin
                    errors++;
                    $display("FAIL pulse_event: got cyc=%0d press=%b rel=%b level=%b expected cyc=%0d press=%b rel=%b level=%b",
                             cyc, key_press, key_release, key_level, e[W-1 -: 32],
                             e[3*NK-1 -: NK], e[2*NK-1 -: NK], e[NK-1:0]);
                end
            end
        end
    end

    initial begin
        int t;
        reset = 1'b1;
        key_n = 4'b1111;
        wait_cyc(3);
        check_level("reset_level", 4'b0000);
        vectors++;
        if (key_press !== 4'b0000 || key_release !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: press=%b release=%b expected 0000/0000", key_press, key_release);
        end
        reset = 1'b0;

        // Idle with all keys released
        wait_cyc(100);
        check_level("idle_level", 4'b0000);

        // Clean press and release of key 0
        key_n[0] = 1'b0; t = cyc;
        expect_event(t + LAT, 4'b0001, 4'b0000, 4'b0001);
        wait_cyc(LAT - 1);
        check_level("k0_before_latency", 4'b0000);
        wait_cyc(9);
        check_level("k0_held", 4'b0001);
        key_n[0] = 1'b1; t = cyc;
        expect_event(t + LAT, 4'b0000, 4'b0001, 4'b0000);
        wait_cyc(20);
        check_level("k0_released", 4'b0000);

        // Key 1 bounce: low 5 / high 3, four times
        for (int i = 0; i < 4; i++) begin
            key_n[1] = 1'b0; wait_cyc(5);
            key_n[1] = 1'b1; wait_cyc(3);
        end
        wait_cyc(20);
        check_level("k1_bounce", 4'b0000);

        // Keys 2 and 3 together, then release key 2 only, then key 3
        key_n[3:2] = 2'b00; t = cyc;
        expect_event(t + LAT, 4'b1100, 4'b0000, 4'b1100);
        wait_cyc(20);
        check_level("k23_held", 4'b1100);
        key_n[2] = 1'b1; t = cyc;
        expect_event(t + LAT, 4'b0000, 4'b0100, 4'b1000);
        wait_cyc(20);
        check_level("k2_released", 4'b1000);
        key_n[3] = 1'b1; t = cyc;
        expect_event(t + LAT, 4'b0000, 4'b1000, 4'b0000);
        wait_cyc(20);

        // Reset in the middle of qualifying key 0 (counter at 5)
        key_n[0] = 1'b0; t = cyc;
        wait_cyc(8);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0; t = cyc;
        check_level("after_mid_reset", 4'b0000);
        expect_event(t + LAT, 4'b0001, 4'b0000, 4'b0001);
        wait_cyc(20);
        check_level("k0_requalified", 4'b0001);
        key_n[0] = 1'b1; t = cyc;
        expect_event(t + LAT, 4'b0000, 4'b0001, 4'b0000);
        wait_cyc(20);

        // Key 3 held, 7-clock high glitch, then a 9-clock release
        key_n[3] = 1'b0; t = cyc;
        expect_event(t + LAT, 4'b1000, 4'b0000, 4'b1000);
        wait_cyc(20);
        key_n[3] = 1'b1; wait_cyc(7);
        key_n[3] = 1'b0; wait_cyc(20);
        check_level("k3_glitch", 4'b1000);
        key_n[3] = 1'b1; t = cyc;
        expect_event(t + LAT, 4'b0000, 4'b1000, 4'b0000);
        expect_event(t + 9 + LAT, 4'b1000, 4'b0000, 4'b1000);
        wait_cyc(9);
        key_n[3] = 1'b0;
        wait_cyc(3);
        check_level("k3_release9", 4'b0000);
        wait_cyc(20);
        check_level("k3_repressed", 4'b1000);
        key_n[3] = 1'b1; t = cyc;
        expect_event(t + LAT, 4'b0000, 4'b1000, 4'b0000);
        wait_cyc(20);
        check_level("final_level", 4'b0000);

        // Every queued event must have been seen
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events not seen, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/nios_system_de2_key_debounce.md
NIOS_SYSTEM_DE2_KEY_DEBOUNCE -- requirements
Module: nios_system_de2_key_debounce

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of independent pushbutton channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: required stable clocks, i.e. 20 ms at 50 MHz; legal range 2..2^24.
REQ-003 Parameter CNT_W, default 24: debounce counter width; SHALL satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 key_n  input  NUM_KEYS  raw DE2 pushbuttons, active-low, asynchronous to clk.
REQ-007 key_level  output  NUM_KEYS  debounced state, 1 = pressed; drives the keys PIO in_port.
REQ-008 key_press  output  NUM_KEYS  one-clock pulse per accepted press.
REQ-009 key_release  output  NUM_KEYS  one-clock pulse per accepted release.

Function
REQ-010 Each key_n bit SHALL pass through a 2-flop synchronizer; the sync output is inverted to active-high "pressed".
REQ-011 Each channel SHALL run an independent FSM with states UP, WAIT_DOWN, DOWN and WAIT_UP, plus a CNT_W-bit counter.
REQ-012 UP: if pressed, go to WAIT_DOWN and clear the counter; else hold.
REQ-013 WAIT_DOWN: if pressed and counter == DEBOUNCE_CYCLES-1, go to DOWN; if pressed otherwise, increment the counter; if released, return to UP and clear the counter.
REQ-014 DOWN: if released, go to WAIT_UP and clear the counter; else hold.
REQ-015 WAIT_UP: symmetric to WAIT_DOWN; reaching DEBOUNCE_CYCLES-1 while released goes to UP; a press returns to DOWN and clears the counter.
REQ-016 key_level SHALL be registered and high exactly in state DOWN or WAIT_UP.
REQ-017 key_press SHALL be high for exactly the one cycle after the WAIT_DOWN->DOWN transition, coincident with the first key_level=1 cycle; key_release behaves likewise for WAIT_UP->UP.
REQ-018 Latency: a clean edge on key_n, stable thereafter, SHALL change key_level exactly DEBOUNCE_CYCLES+3 clock edges later.
REQ-019 Any bounce shorter than DEBOUNCE_CYCLES consecutive stable clocks SHALL produce no output change and no pulse.
REQ-020 The counter SHALL never wrap; it only increments in the WAIT states and stops at DEBOUNCE_CYCLES-1.
REQ-021 Simultaneous activity on several keys SHALL be handled independently, with no cross-channel interaction; multiple pulse bits may be high in the same cycle.
REQ-022 key_press and key_release for the same key SHALL never be high in the same cycle.

Reset
REQ-023 When reset is high: synchronizer flops SHALL be set to 1 (released), all FSMs to UP, counters to 0, and key_level, key_press and key_release to 0.
REQ-024 Reset asserted mid-debounce or while a key is held SHALL abort the operation with no pulse; a key still held after reset SHALL be re-qualified from UP (press pulse after DEBOUNCE_CYCLES+3 clocks).

Structure
REQ-025 Package nios_system_de2_key_pkg SHALL hold the FSM state enum (UP, WAIT_DOWN, DOWN, WAIT_UP) and the DEBOUNCE_CYCLES and CNT_W defaults.
REQ-026 Sub-module nios_system_de2_key_debounce_ch SHALL implement one channel (synchronizer, FSM, counter, pulses); the top SHALL instantiate NUM_KEYS copies via generate.

Verification (bench uses DEBOUNCE_CYCLES=8)
REQ-027 key_n=4'b1111 held through reset, then idle for 100 clocks -> key_level=0000 and no pulses throughout.
REQ-028 key_n[0] falls and stays low -> key_level[0]=1 and key_press[0] one-cycle pulse, both exactly 11 edges after the fall.
REQ-029 key_n[1] toggles low 5 clocks / high 3 clocks, four times, then high -> key_level[1] stays 0 and key_press[1] never asserts.
REQ-030 key_n[2] and key_n[3] fall on the same clock -> both key_press bits pulse in the same cycle; a later release of key_n[2] only -> key_release=0100 for one cycle and key_level=1000.
REQ-031 key_n[0] low, reset pulsed for 1 clock at debounce count 5, key held -> no pulse before reset; key_press[0] pulses 11 edges after reset deasserts.
REQ-032 Held key with a 7-clock high glitch -> key_level stays 1 and no release pulse; a 9-clock release -> key_release pulse, and key_level=0.
